// File: rtl/simd_pkg.sv
// simd_pkg
// Shared definitions for the 4-lane SIMD datapath: lane geometry, vector
// register file size, ALU select codes, the issue record carried from the
// operand stage to the ALU, and the operand-stage buffer states.
package simd_pkg;

    localparam int LANES    = 4;
    localparam int LANE_W   = 8;
    localparam int VREG_W   = LANES * LANE_W;
    localparam int NVREG    = 16;
    localparam int VREG_AW  = $clog2(NVREG);

    // Lane-wise ops occupy 3'b000..3'b011; MixColumns uses only operand A.
    localparam logic [2:0] OP_LANE_ADD = 3'b000;
    localparam logic [2:0] OP_LANE_SUB = 3'b001;
    localparam logic [2:0] OP_LANE_XOR = 3'b010;
    localparam logic [2:0] OP_LANE_AND = 3'b011;
    localparam logic [2:0] OP_MIXCOL   = 3'b101;

    typedef struct packed {
        logic [VREG_W-1:0]  a;
        logic [VREG_W-1:0]  b;
        logic [2:0]         select;
        logic [VREG_AW-1:0] rd;
    } simd_issue_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // Replicate an immediate byte into every lane.
    function automatic logic [VREG_W-1:0] broadcast_byte(input logic [LANE_W-1:0] imm);
        return {LANES{imm}};
    endfunction

endpackage

// File: rtl/simd_vreg_file.sv
// simd_vreg_file
// NREGS x W vector register file, two combinational read ports and one
// write port. A write in the same cycle as a read of the same index is
// forwarded to the read port (write-first). Synchronous active-high reset
// clears every register; reset wins over a same-cycle write.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rd_addr_a / rd_data_a     read port A
//   rd_addr_b / rd_data_b     read port B
//   wr_en, wr_addr, wr_data   write port
module simd_vreg_file
    import simd_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] rd_addr_a,
    output logic [W-1:0]             rd_data_a,
    input  logic [$clog2(NREGS)-1:0] rd_addr_b,
    output logic [W-1:0]             rd_data_b,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data
);

    logic [W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/simd_operand_stage.sv
// simd_operand_stage
// Operand-fetch stage in front of the SIMD ALU. Reads two source vectors
// (with writeback bypass), optionally replaces operand B by a broadcast
// immediate byte, and hands {a, b, select, rd} to the ALU through a
// registered valid/ready port backed by a 2-entry skid buffer.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid / in_ready              decoded-instruction handshake
//   in_rs1, in_rs2, in_rd, in_op     source/destination indices, ALU select
//   in_imm_en, in_imm                broadcast immediate for operand B
//   wb_en, wb_addr, wb_data          register-file writeback
//   out_valid / out_ready            ALU handshake
//   out_a, out_b, out_select, out_rd operands and tag from the main register
//
// Buffer states:
//   state     | meaning
//   BUF_EMPTY | nothing held, in_ready=1, out_valid=0
//   BUF_ONE   | main register holds head entry, in_ready=1, out_valid=1
//   BUF_TWO   | main + skid both full, in_ready=0, out_valid=1
module simd_operand_stage
    import simd_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NREGS)-1:0] in_rs1,
    input  logic [$clog2(NREGS)-1:0] in_rs2,
    input  logic [$clog2(NREGS)-1:0] in_rd,
    input  logic [2:0]               in_op,
    input  logic                     in_imm_en,
    input  logic [7:0]               in_imm,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_addr,
    input  logic [W-1:0]             wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_a,
    output logic [W-1:0]             out_b,
    output logic [2:0]               out_select,
    output logic [$clog2(NREGS)-1:0] out_rd
);

    logic [W-1:0] rf_a;
    logic [W-1:0] rf_b;
    simd_issue_t  issue_new;
    simd_issue_t  main_q;
    simd_issue_t  skid_q;
    buf_state_t   state;
    logic         accept;
    logic         xfer;

    simd_vreg_file #(
        .NREGS (NREGS),
        .W     (W)
    ) u_vreg_file (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (in_rs1),
        .rd_data_a (rf_a),
        .rd_addr_b (in_rs2),
        .rd_data_b (rf_b),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

    // Operand B is formed the same way for MixColumns; the ALU ignores it.
    always_comb begin
        issue_new.a      = rf_a;
        issue_new.b      = in_imm_en ? broadcast_byte(in_imm) : rf_b;
        issue_new.select = in_op;
        issue_new.rd     = in_rd;
    end

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;

    // in_ready and out_valid are registered alongside the state so that
    // in_ready never depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BUF_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_q    <= issue_new;
                        state     <= BUF_ONE;
                        out_valid <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (accept && !xfer) begin
                        skid_q   <= issue_new;
                        state    <= BUF_TWO;
                        in_ready <= 1'b0;
                    end else if (xfer && !accept) begin
                        state     <= BUF_EMPTY;
                        out_valid <= 1'b0;
                    end else if (accept && xfer) begin
                        main_q <= issue_new;
                    end
                end
                BUF_TWO: begin
                    if (xfer) begin
                        main_q   <= skid_q;
                        state    <= BUF_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= BUF_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_a      = main_q.a;
    assign out_b      = main_q.b;
    assign out_select = main_q.select;
    assign out_rd     = main_q.rd;

endmodule

// File: tb/tb_simd_operand_stage.sv
module tb_simd_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rs1, in_rs2, in_rd;
    logic [2:0]  in_op;
    logic        in_imm_en;
    logic [7:0]  in_imm;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a, out_b;
    logic [2:0]  out_select;
    logic [3:0]  out_rd;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [3:0]  rd;
    } entry_t;

    entry_t      exp_q[$];
    logic [31:0] mreg[16];

    simd_operand_stage #(.NREGS(16), .W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_op      (in_op),
        .in_imm_en  (in_imm_en),
        .in_imm     (in_imm),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_select (out_select),
        .out_rd     (out_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a 2-deep FIFO of captured operands plus an array register file.
    function automatic logic [31:0] model_read(input logic [3:0] idx);
        if (wb_en && wb_addr == idx) return wb_data;
        return mreg[idx];
    endfunction

    task automatic model_step();
        entry_t e;
        bit acc, xf;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) mreg[i] = 32'h0;
        end else begin
            acc = in_valid && (exp_q.size() < 2);
            xf  = (exp_q.size() > 0) && out_ready;
            e.a   = model_read(in_rs1);
            e.b   = in_imm_en ? {in_imm, in_imm, in_imm, in_imm} : model_read(in_rs2);
            e.sel = in_op;
            e.rd  = in_rd;
            if (xf) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
            if (wb_en) mreg[wb_addr] = wb_data;
        end
    endtask

    task automatic check_outputs();
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
        if (exp_q.size() != 0) begin
            check("out_a", out_a, exp_q[0].a);
            check("out_b", out_b, exp_q[0].b);
            check("out_select", {29'b0, out_select}, {29'b0, exp_q[0].sel});
            check("out_rd", {28'b0, out_rd}, {28'b0, exp_q[0].rd});
        end
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then check.
    task automatic step(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [3:0] rd, input logic [2:0] op, input logic ie,
                        input logic [7:0] imm, input logic we, input logic [3:0] wa,
                        input logic [31:0] wd, input logic ordy);
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_op = op;
        in_imm_en = ie; in_imm = imm; wb_en = we; wb_addr = wa; wb_data = wd;
        out_ready = ordy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Reset with a live instruction and write present: reset must win.
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b1; in_rs1 = 4'd3; in_rs2 = 4'd3; in_rd = 4'd9; in_op = 3'd1;
        in_imm_en = 1'b0; in_imm = 8'h0; wb_en = 1'b1; wb_addr = 4'd3;
        wb_data = 32'hCAFEF00D; out_ready = 1'b0;
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_a", out_a, 32'd0);
        check("rst_out_b", out_b, 32'd0);
        check("rst_out_select", {29'b0, out_select}, 32'd0);
        check("rst_out_rd", {28'b0, out_rd}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_op = 0;
        in_imm_en = 0; in_imm = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
        @(negedge clk);
        do_reset();

        // Write then read the same register.
        step(0, 0, 0, 0, 3'b000, 0, 8'h00, 1, 4'd3, 32'h11223344, 1);
        step(1, 4'd3, 4'd3, 4'd7, 3'b000, 0, 8'h00, 0, 0, 0, 1);
        check("wr_rd_a", out_a, 32'h11223344);
        check("wr_rd_b", out_b, 32'h11223344);
        check("wr_rd_sel", {29'b0, out_select}, 32'd0);
        check("wr_rd_valid", {31'b0, out_valid}, 32'd1);

        // Same-cycle bypass.
        step(1, 4'd5, 4'd3, 4'd2, 3'b010, 0, 8'h00, 1, 4'd5, 32'hDEADBEEF, 1);
        check("bypass_a", out_a, 32'hDEADBEEF);

        // Broadcast immediate with MixColumns select.
        step(1, 4'd5, 4'd3, 4'd4, 3'b101, 1, 8'h1B, 0, 0, 0, 1);
        check("imm_b", out_b, 32'h1B1B1B1B);
        check("imm_sel", {29'b0, out_select}, 32'd5);
        step(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1);

        // Backpressure: A, B accepted, C held until space frees.
        step(1, 4'd3, 4'd5, 4'd1, 3'b000, 0, 8'h00, 0, 0, 0, 0);
        check("bp_a_rd", {28'b0, out_rd}, 32'd1);
        step(1, 4'd5, 4'd3, 4'd2, 3'b001, 0, 8'h00, 0, 0, 0, 0);
        check("bp_b_full", {31'b0, in_ready}, 32'd0);
        step(1, 4'd3, 4'd3, 4'd3, 3'b011, 0, 8'h00, 0, 0, 0, 0);
        check("bp_c_held_rd", {28'b0, out_rd}, 32'd1);
        check("bp_c_held_rdy", {31'b0, in_ready}, 32'd0);
        step(1, 4'd3, 4'd3, 4'd3, 3'b011, 0, 8'h00, 0, 0, 0, 1);
        check("bp_out_b", {28'b0, out_rd}, 32'd2);
        step(1, 4'd3, 4'd3, 4'd3, 3'b011, 0, 8'h00, 0, 0, 0, 1);
        check("bp_out_c", {28'b0, out_rd}, 32'd3);
        check("bp_out_c_valid", {31'b0, out_valid}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        check("bp_drained", {31'b0, out_valid}, 32'd0);

        // Reset while full.
        step(1, 4'd3, 4'd5, 4'd1, 3'b000, 0, 8'h00, 0, 0, 0, 0);
        step(1, 4'd3, 4'd5, 4'd2, 3'b000, 0, 8'h00, 0, 0, 0, 0);
        check("pre_rst_full", {31'b0, in_ready}, 32'd0);
        do_reset();
        step(1, 4'd3, 4'd5, 4'd6, 3'b000, 0, 8'h00, 0, 0, 0, 0);
        check("post_rst_r3", out_a, 32'd0);
        check("post_rst_r5", out_b, 32'd0);
        step(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1);

        // Random stress against the reference model.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if ($urandom_range(0, 1999) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7,
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                     $urandom_range(0, 3) == 0, 8'($urandom),
                     $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                     32'($urandom), $urandom_range(0, 9) < 6);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/simd_operand_stage.md
# simd_operand_stage

Operand-fetch stage directly upstream of the 4-lane SIMD ALU (4×8-bit lanes plus MixColumns GF multiply). It holds the 16×32-bit vector register file, reads two source operands with writeback bypass, optionally substitutes a broadcast byte immediate for operand B, and delivers `a`, `b`, `select` and the destination tag to the ALU through a registered valid/ready output with a 2-entry skid buffer, so full throughput is kept under backpressure.

## Interface
- `NREGS`, 16: number of vector registers (power of 2).
- `W`, 32: vector width; must equal 4 × 8.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage can accept this cycle.
- `in_rs1`, `in_rs2`, `in_rd`  in  $clog2(NREGS) each  source A, source B, destination indices.
- `in_op`  in  3  ALU select code, passed through.
- `in_imm_en`  in  1  replace operand B with broadcast immediate.
- `in_imm`  in  8  immediate byte.
- `wb_en`  in  1  register-file write strobe.
- `wb_addr`  in  $clog2(NREGS)  write index.
- `wb_data`  in  W  write data.
- `out_valid`  out  1  operands valid to ALU.
- `out_ready`  in  1  ALU/next stage accepts.
- `out_a`, `out_b`  out  W  operands.
- `out_select`  out  3  ALU select.
- `out_rd`  out  $clog2(NREGS)  destination tag for writeback.

## Operation
- Register file: NREGS×W, all entries reset to 0; all registers writable (no hard-wired zero).
- Write: `wb_en` writes `wb_data` to `wb_addr` at clock edge.
- Read: combinational on `in_rs1`/`in_rs2`; if `wb_en` and `wb_addr` matches a source index, that operand takes `wb_data` (bypass, write-first).
- Operand B: `in_imm_en` ? `{4{in_imm}}` : bypassed read of `in_rs2`.
- `in_op` == 3'b101 (MixColumns): B computed by the normal rule; ALU ignores it.
- Operands captured at accept; later writebacks do not update already-captured entries. RAW hazard avoidance beyond same-cycle bypass belongs to decode.
- Accept: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- Buffer state machine, states EMPTY / ONE / TWO (main register + skid register):
  - EMPTY: accept → ONE.
  - ONE: accept & no transfer → TWO (new entry to skid); transfer & no accept → EMPTY; both → ONE (new entry into main); neither → ONE.
  - TWO: transfer → ONE (skid moves to main); no accept possible.
- Order strictly FIFO; no entry dropped or duplicated.
- `in_ready` = registered, 1 in EMPTY/ONE, 0 in TWO.
- `out_valid` = 1 in ONE/TWO; outputs come from main register only.
- Output fields hold stable while `out_valid && !out_ready`.

## Timing
- Latency: accept at edge N → `out_valid` from N+1 (from EMPTY).
- Throughput: 1 op/cycle while `out_ready` high.
- `in_ready` drops the cycle after entering TWO; it is never combinationally dependent on `out_ready`.
- Reset: `rst` high at an edge → state EMPTY, `out_valid`=0, `in_ready`=1, `out_a`=`out_b`=0, `out_select`=0, `out_rd`=0, all registers 0. `rst` beats same-cycle `in_valid` and `wb_en`: nothing accepted, nothing written.
- Reset mid-operation: buffered entries discarded, no partial output.
- Same-cycle write to a register in use and read of it: read returns new data.

## Structure
- Shared package `simd_pkg`: `LANES`=4, `LANE_W`=8, `VREG_W`=32, `NVREG`=16, select codes (`OP_MIXCOL`=3'b101, lane ops 3'b000–3'b011), and a packed struct `simd_issue_t` {a, b, select, rd} used by the main/skid registers and the ALU stage.
- One sub-module: `simd_vreg_file` (2R1W, reset, write-first bypass). The skid buffer and FSM stay in the top module.

## Test plan
- Write reg 3 = 0x11223344, next cycle issue rs1=3, rs2=3, op=000 → one cycle later `out_a`=`out_b`=0x11223344, `out_select`=0, `out_valid`=1.
- Same-cycle bypass: `wb_en` reg 5 = 0xDEADBEEF while issuing rs1=5 → `out_a`=0xDEADBEEF.
- Immediate: `in_imm_en`=1, `in_imm`=0x1B, op=101 → `out_b`=0x1B1B1B1B, `out_select`=3'b101.
- Backpressure: `out_ready`=0, issue ops A, B, C back-to-back → A and B accepted, `in_ready`=0 in the cycle C is offered and C is held. Raise `out_ready` → outputs A, B, C in order with no gaps.
- Reset mid-stream in state TWO → next cycle `out_valid`=0, `in_ready`=1; a read of any register returns 0.
- Random stress: random `in_valid`/`out_ready`/`wb_en` for 10k cycles checked against a FIFO/regfile scoreboard, with no loss, duplication or reordering.
